// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared state encodings and control-output patterns for the
//              ID/EX hazard controller and its load-use comparator.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int REG_AW_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_FLUSH = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_SPARE    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NORMAL   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_STALL    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_BR_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

`default_nettype wire

// File: rtl/hazard_loaduse_cmp.sv
// ============================================================================
// hazard_loaduse_cmp : combinational load-use detector between the load in EX
//                      and the source operands of the instruction in ID.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module hazard_loaduse_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_use
);

  logic hit_rs;
  logic hit_rt;

  // Register 0 is an ordinary register here; no zero-register exemption.
  always_comb begin
    hit_rs   = (ex_dst == id_rs);
    hit_rt   = id_uses_rt && (ex_dst == id_rt);
    load_use = ex_memread && id_valid && (hit_rs || hit_rt);
  end

endmodule

`default_nettype wire

// File: rtl/idex_hazard_ctrl.sv
// ============================================================================
// idex_hazard_ctrl : stall/flush controller for load-use, taken branches and
//                    multi-cycle multiply/divide occupancy of EX.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module idex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW        = REG_AW_DEF,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifid_valid,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              ifid_is_muldiv,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              muldiv_busy,
  output logic [1:0]        hazard_state
);

  localparam bit             MD_MULTI = (MULDIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MD_LOAD = MD_MULTI ? CNT_W'(MULDIV_CYCLES - 2) : '0;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hz_ctrl_t         ctrl;
  logic             busy;
  logic             load_use;

  hazard_loaduse_cmp #(
    .REG_AW (REG_AW)
  ) u_loaduse_cmp (
    .ex_memread (idex_memread),
    .ex_dst     (idex_rt),
    .id_valid   (ifid_valid),
    .id_rs      (ifid_rs),
    .id_rt      (ifid_rt),
    .id_uses_rt (ifid_uses_rt),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NORMAL;
    busy    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ctrl    = CTRL_BRANCH;
          state_d = ST_BR_FLUSH;
        end else if (load_use) begin
          // Single bubble; the muldiv check is re-run once the load has moved on.
          ctrl = CTRL_STALL;
        end else if (ifid_valid && ifid_is_muldiv && MD_MULTI) begin
          state_d = ST_MD_WAIT;
          cnt_d   = MD_LOAD;
        end
      end
      ST_BR_FLUSH: begin
        ctrl    = CTRL_BR_FLUSH;
        state_d = ST_RUN;
      end
      ST_MD_WAIT: begin
        ctrl = CTRL_STALL;
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        ctrl    = CTRL_RESET;
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset must force the buffers into bubble mode regardless of state.
  always_comb begin
    if (!rst) begin
      pc_write     = CTRL_RESET.pc_write;
      ifid_write   = CTRL_RESET.ifid_write;
      ifid_flush   = CTRL_RESET.ifid_flush;
      idex_flush   = CTRL_RESET.idex_flush;
      muldiv_busy  = 1'b0;
      hazard_state = ST_RUN;
    end else begin
      pc_write     = ctrl.pc_write;
      ifid_write   = ctrl.ifid_write;
      ifid_flush   = ctrl.ifid_flush;
      idex_flush   = ctrl.idex_flush;
      muldiv_busy  = busy;
      hazard_state = state_q;
    end
  end

endmodule

`default_nettype wire
